// File: rtl/icache_refill_ctrl.sv
// ---------------------------------------------------------------------------
// icache_refill_ctrl
//
// Initiator side of the 512-bit instruction-cache line-fill interface.
// On a miss it issues a line-aligned request to instruction memory and
// holds it until memory answers with a single-cycle mem_ready pulse. The
// returned 16-word line is then written into the direct-mapped cache array
// together with its index and tag. A decode-stage redirect cancels an
// outstanding fill: the request still has to complete (memory has no
// cancel), but the returned data is discarded and fetch is released early.
// A watchdog aborts requests that memory never answers.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset (0 = reset asserted)
//   miss         cache lookup for miss_addr missed this cycle
//   miss_addr    fetch PC that missed
//   redirect     decode-stage redirect; cancels the outstanding fill
//   mem_ready    single-cycle pulse, mem_rdata valid in the same cycle
//   mem_rdata    returned line, word k at bits 32k+31:32k
//   mem_req      request outstanding
//   mem_addr     line-aligned request address (bits 5:0 = 0)
//   fill_we      one-cycle write strobe to the cache array
//   fill_index   line index to write
//   fill_tag     tag to write (array sets the valid bit on fill_we)
//   fill_data    registered line data
//   busy         stall request to fetch
//   timeout_err  sticky watchdog-expiry flag
// ---------------------------------------------------------------------------
module icache_refill_ctrl #(
    parameter int NUM_LINES = 8,
    parameter int IDX_W     = $clog2(NUM_LINES),
    parameter int TAG_W     = 26 - IDX_W,
    parameter int TIMEOUT   = 63
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               miss,
    input  logic [31:0]        miss_addr,
    input  logic               redirect,
    input  logic               mem_ready,
    input  logic [511:0]       mem_rdata,
    output logic               mem_req,
    output logic [31:0]        mem_addr,
    output logic               fill_we,
    output logic [IDX_W-1:0]   fill_index,
    output logic [TAG_W-1:0]   fill_tag,
    output logic [511:0]       fill_data,
    output logic               busy,
    output logic               timeout_err
);

    localparam int WD_W = 6;
    // The watchdog fires on the TIMEOUT-th cycle spent waiting, i.e. when
    // the count of already-elapsed waiting cycles equals TIMEOUT-1.
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DROP,
        S_FILL
    } state_t;

    state_t          state_reg;
    logic [WD_W-1:0] wd_cnt_reg;

    logic            wd_expire;
    logic [WD_W-1:0] wd_cnt_inc;

    assign wd_expire  = (wd_cnt_reg == WD_LAST);
    // Saturating increment: the counter never wraps back to a small value.
    assign wd_cnt_inc = (wd_cnt_reg == {WD_W{1'b1}}) ? wd_cnt_reg : wd_cnt_reg + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= S_IDLE;
            wd_cnt_reg  <= '0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            fill_we     <= 1'b0;
            fill_index  <= '0;
            fill_tag    <= '0;
            fill_data   <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    fill_we <= 1'b0;
                    // A redirect in the same cycle means the missing PC is
                    // already stale, so the miss is not serviced.
                    if (miss && !redirect) begin
                        mem_addr   <= {miss_addr[31:6], 6'b0};
                        mem_req    <= 1'b1;
                        busy       <= 1'b1;
                        wd_cnt_reg <= '0;
                        state_reg  <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (mem_ready) begin
                        // Data arriving with a redirect is still a valid
                        // line for this address, so it is kept.
                        fill_data  <= mem_rdata;
                        fill_index <= mem_addr[5+IDX_W:6];
                        fill_tag   <= mem_addr[31:6+IDX_W];
                        fill_we    <= 1'b1;
                        mem_req    <= 1'b0;
                        wd_cnt_reg <= '0;
                        state_reg  <= S_FILL;
                    end else if (wd_expire) begin
                        timeout_err <= 1'b1;
                        mem_req     <= 1'b0;
                        busy        <= 1'b0;
                        wd_cnt_reg  <= '0;
                        state_reg   <= S_IDLE;
                    end else begin
                        wd_cnt_reg <= wd_cnt_inc;
                        if (redirect) begin
                            // Release fetch now; the request itself must
                            // still run to completion in DROP.
                            busy      <= 1'b0;
                            state_reg <= S_DROP;
                        end
                    end
                end

                S_DROP: begin
                    if (mem_ready) begin
                        mem_req    <= 1'b0;
                        busy       <= 1'b0;
                        wd_cnt_reg <= '0;
                        state_reg  <= S_IDLE;
                    end else if (wd_expire) begin
                        timeout_err <= 1'b1;
                        mem_req     <= 1'b0;
                        busy        <= 1'b0;
                        wd_cnt_reg  <= '0;
                        state_reg   <= S_IDLE;
                    end else begin
                        wd_cnt_reg <= wd_cnt_inc;
                        // A new miss cannot be taken while the cancelled
                        // request is still in flight, so stall fetch instead.
                        busy       <= miss;
                    end
                end

                S_FILL: begin
                    fill_we   <= 1'b0;
                    busy      <= 1'b0;
                    state_reg <= S_IDLE;
                end

                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// ---------------------------------------------------------------------------
// tb_icache_refill_ctrl
//
// Directed bench for icache_refill_ctrl. Expected cache fills are pushed
// into a scoreboard queue when a miss is issued; a monitor thread pops and
// compares them whenever the DUT strobes fill_we. Control outputs are
// checked directly against hand-computed values at fixed cycle offsets.
// ---------------------------------------------------------------------------
module tb_icache_refill_ctrl;

    localparam int NUM_LINES = 8;
    localparam int IDX_W     = 3;
    localparam int TAG_W     = 23;

    logic               clk;
    logic               reset;
    logic               miss;
    logic [31:0]        miss_addr;
    logic               redirect;
    logic               mem_ready;
    logic [511:0]       mem_rdata;
    logic               mem_req;
    logic [31:0]        mem_addr;
    logic               fill_we;
    logic [IDX_W-1:0]   fill_index;
    logic [TAG_W-1:0]   fill_tag;
    logic [511:0]       fill_data;
    logic               busy;
    logic               timeout_err;

    icache_refill_ctrl #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W),
        .TIMEOUT   (63)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .miss        (miss),
        .miss_addr   (miss_addr),
        .redirect    (redirect),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .fill_we     (fill_we),
        .fill_index  (fill_index),
        .fill_tag    (fill_tag),
        .fill_data   (fill_data),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [IDX_W-1:0] idx;
        logic [TAG_W-1:0] tag;
        logic [511:0]     data;
    } fill_t;

    fill_t sb[$];
    int    errors = 0;
    int    checks = 0;

    function automatic logic [511:0] make_line(input logic [31:0] base);
        logic [511:0] l;
        l = '0;
        for (int k = 0; k < 16; k++) l[32*k +: 32] = base + 32'(k);
        return l;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s = 0x%08h", name, act);
        end
    endtask

    task automatic push_fill(input logic [IDX_W-1:0] idx, input logic [TAG_W-1:0] tag,
                             input logic [511:0] data);
        fill_t f;
        f.idx  = idx;
        f.tag  = tag;
        f.data = data;
        sb.push_back(f);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive a one-cycle mem_ready pulse starting at the current negedge.
    task automatic ready_pulse(input logic [511:0] data);
        mem_ready = 1'b1;
        mem_rdata = data;
        tick(1);
        mem_ready = 1'b0;
        mem_rdata = '0;
    endtask

    initial begin
        reset     = 1'b0;
        miss      = 1'b0;
        miss_addr = '0;
        redirect  = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = '0;

        // Monitor: compares every fill strobe against the scoreboard.
        fork
            begin : monitor
                logic prev_we;
                fill_t f;
                prev_we = 1'b0;
                forever begin
                    @(negedge clk);
                    if (reset && fill_we) begin
                        if (prev_we) chk("fill_we_single_cycle", 32'(prev_we), 32'd0);
                        if (sb.size() == 0) begin
                            chk("unexpected_fill_we", 32'(fill_we), 32'd0);
                        end else begin
                            f = sb.pop_front();
                            chk("fill_index", 32'(fill_index), 32'(f.idx));
                            chk("fill_tag", 32'(fill_tag), 32'(f.tag));
                            checks++;
                            if (fill_data !== f.data) begin
                                errors++;
                                $display("FAIL fill_data: got %h expected %h", fill_data, f.data);
                            end else begin
                                $display("ok   fill_data word2 = 0x%08h", fill_data[95:64]);
                            end
                        end
                    end
                    prev_we = reset ? fill_we : 1'b0;
                end
            end
        join_none

        // ---- reset state ----
        tick(2);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fill_we", 32'(fill_we), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        reset = 1'b1;
        tick(1);

        // ---- basic fill: 0x48 -> line 0x40, index 1, tag 0 ----
        miss = 1'b1; miss_addr = 32'h0000_0048;
        push_fill(3'd1, 23'd0, make_line(32'd0));
        tick(1);
        miss = 1'b0;
        chk("basic_mem_req", 32'(mem_req), 32'd1);
        chk("basic_busy", 32'(busy), 32'd1);
        chk("basic_mem_addr", mem_addr, 32'h0000_0040);
        tick(18);
        chk("basic_mem_addr_held", mem_addr, 32'h0000_0040);
        chk("basic_busy_held", 32'(busy), 32'd1);
        ready_pulse(make_line(32'd0));
        chk("basic_fill_we", 32'(fill_we), 32'd1);
        chk("basic_req_dropped", 32'(mem_req), 32'd0);
        chk("basic_busy_in_fill", 32'(busy), 32'd1);
        tick(1);
        chk("basic_busy_after", 32'(busy), 32'd0);
        chk("basic_fill_we_after", 32'(fill_we), 32'd0);

        // ---- redirect during WAIT: no fill ----
        miss = 1'b1; miss_addr = 32'h0000_0080;
        tick(1);
        miss = 1'b0;
        chk("redir_mem_addr", mem_addr, 32'h0000_0080);
        tick(4);
        redirect = 1'b1;
        tick(1);
        redirect = 1'b0;
        chk("redir_busy_low", 32'(busy), 32'd0);
        chk("redir_req_high", 32'(mem_req), 32'd1);
        miss = 1'b1; miss_addr = 32'h0000_2000;
        tick(1);
        miss = 1'b0;
        chk("drop_miss_busy", 32'(busy), 32'd1);
        chk("drop_addr_held", mem_addr, 32'h0000_0080);
        tick(1);
        chk("drop_busy_released", 32'(busy), 32'd0);
        tick(10);
        ready_pulse(make_line(32'hDEAD_0000));
        chk("drop_req_dropped", 32'(mem_req), 32'd0);
        chk("drop_no_fill", 32'(fill_we), 32'd0);
        chk("drop_busy", 32'(busy), 32'd0);
        tick(2);

        // ---- redirect coincident with mem_ready: fill kept ----
        miss = 1'b1; miss_addr = 32'h0000_0FC4;
        push_fill(3'd7, 23'd7, make_line(32'h100));
        tick(1);
        miss = 1'b0;
        chk("coinc_mem_addr", mem_addr, 32'h0000_0FC0);
        tick(3);
        redirect = 1'b1;
        ready_pulse(make_line(32'h100));
        redirect = 1'b0;
        chk("coinc_fill_we", 32'(fill_we), 32'd1);
        chk("coinc_busy", 32'(busy), 32'd1);
        tick(1);
        chk("coinc_busy_after", 32'(busy), 32'd0);

        // ---- miss and redirect together in IDLE ----
        miss = 1'b1; redirect = 1'b1; miss_addr = 32'h0000_0500;
        tick(1);
        miss = 1'b0; redirect = 1'b0;
        chk("mr_mem_req", 32'(mem_req), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        tick(1);
        chk("mr_mem_req_later", 32'(mem_req), 32'd0);

        // ---- timeout ----
        miss = 1'b1; miss_addr = 32'h0000_0100;
        tick(1);
        miss = 1'b0;
        chk("to_mem_req", 32'(mem_req), 32'd1);
        tick(62);
        chk("to_req_before", 32'(mem_req), 32'd1);
        chk("to_err_before", 32'(timeout_err), 32'd0);
        tick(1);
        chk("to_req_after", 32'(mem_req), 32'd0);
        chk("to_err_after", 32'(timeout_err), 32'd1);
        chk("to_busy_after", 32'(busy), 32'd0);
        tick(1);
        chk("to_no_fill", 32'(fill_we), 32'd0);
        miss = 1'b1; miss_addr = 32'h0000_02C0;
        push_fill(3'd3, 23'd1, make_line(32'h300));
        tick(1);
        miss = 1'b0;
        chk("to_next_mem_addr", mem_addr, 32'h0000_02C0);
        tick(2);
        ready_pulse(make_line(32'h300));
        chk("to_next_fill_we", 32'(fill_we), 32'd1);
        chk("to_err_sticky", 32'(timeout_err), 32'd1);
        tick(1);

        // ---- asynchronous reset mid-WAIT ----
        miss = 1'b1; miss_addr = 32'h0000_0040;
        tick(1);
        miss = 1'b0;
        tick(3);
        #2 reset = 1'b0;
        #1;
        chk("arst_mem_req", 32'(mem_req), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_mem_addr", mem_addr, 32'd0);
        chk("arst_timeout_err", 32'(timeout_err), 32'd0);
        chk("arst_fill_data_zero", 32'(fill_data == '0), 32'd1);
        chk("arst_fill_tag", 32'(fill_tag), 32'd0);
        tick(1);
        reset = 1'b1;
        ready_pulse(make_line(32'hBAD0_0000));
        chk("stale_ready_req", 32'(mem_req), 32'd0);
        chk("stale_ready_busy", 32'(busy), 32'd0);
        chk("stale_ready_fill", 32'(fill_we), 32'd0);
        miss = 1'b1; miss_addr = 32'h0000_3F80;
        push_fill(3'd6, 23'd31, make_line(32'h200));
        tick(1);
        miss = 1'b0;
        chk("post_rst_mem_addr", mem_addr, 32'h0000_3F80);
        tick(4);
        ready_pulse(make_line(32'h200));
        chk("post_rst_fill_we", 32'(fill_we), 32'd1);
        tick(3);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
